exe_mem_stage_reg: RTL and testbench
====================================

# exe_mem_stage_reg

EXE→MEM pipeline register of the 5-stage ARM-subset core. Captures the ALU result, the store data, the destination register and control bits at the end of the execute stage and holds the architectural NZCV status register fed by the ALU flags. It supports memory-side freeze (stall), branch flush with flush-while-frozen retention, and a forwarding-valid indication for the hazard/forwarding unit.

## Interface
Parameters:
- none

Ports:
- `clk`  in  1  core clock, rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `freeze`  in  1  memory stage busy; hold all state
- `flush`  in  1  squash the instruction entering this register
- `valid_in`  in  1  instruction in EXE is real (not a bubble)
- `wb_en_in`  in  1  writes back to register file
- `mem_r_en_in`  in  1  load
- `mem_w_en_in`  in  1  store
- `s_in`  in  1  instruction updates flags (S bit)
- `dest_in`  in  4  destination register number
- `alu_result_in`  in  32  ALU result / memory address
- `val_rm_in`  in  32  store data
- `status_in`  in  4  ALU flags {N,Z,C,V}
- `valid_out`, `wb_en_out`, `mem_r_en_out`, `mem_w_en_out`  out  1 each  registered control
- `dest_out`  out  4  registered destination
- `alu_result_out`  out  32  registered result
- `val_rm_out`  out  32  registered store data
- `status_out`  out  4  NZCV register; `status_out[1]` drives ALU carry_in
- `fwd_valid`  out  1  `valid_out & wb_en_out & ~mem_r_en_out`

## Operation
- Advance edge = rising `clk` with `freeze`=0. Frozen edge = rising `clk` with `freeze`=1.
- Internal flag `flush_pending` (1 bit).
- Effective squash at an advance edge: `flush | flush_pending`.
- Advance edge, no squash: all `*_out` data/control registers load their `*_in`; `valid_out` ← `valid_in`.
- Advance edge, squash: `valid_out`, `wb_en_out`, `mem_r_en_out`, `mem_w_en_out` ← 0; `dest_out`, `alu_result_out`, `val_rm_out` hold their old values; `flush_pending` ← 0.
- Frozen edge: every output register holds; if `flush`=1 then `flush_pending` ← 1 (not cumulative; multiple flushes while frozen squash exactly one instruction).
- Advance edge without squash: `flush_pending` stays 0.
- Status update: at an advance edge with no squash, `valid_in`=1 and `s_in`=1: `status_out` ← `status_in`; otherwise `status_out` holds. Flags are taken verbatim (logical ops pass whatever C/V the ALU reports).
- `fwd_valid` is combinational from registered outputs only; loads are not forwardable from this stage.
- Bubbles (`valid_in`=0) advance normally; their control inputs are still registered as given. Upstream guarantees control bits are 0 for bubbles.

## Timing
- Latency 1 cycle, EXE inputs → outputs at the next advance edge.
- `status_out` changes on the same edge as `alu_result_out`; the following EXE instruction sees new carry in the same cycle.
- Reset (`rst_n`=0, any time, asynchronous): all outputs 0, `status_out`=4'b0000, `flush_pending`=0. Reset asserted mid-freeze or with pending flush clears everything; first edge after deassertion is an ordinary edge.
- `freeze` and `flush` are sampled only at rising edges; both high at once = frozen edge with flush recorded.

## Configuration
- `EXE_STATUS_REG_EN` defined: NZCV register implemented as above.
- Undefined: no status flops; `status_out` tied to 4'b0000; `s_in` and `status_in` ignored; all other behaviour unchanged.

## Test plan
- Reset: drive all inputs nonzero, pulse `rst_n` low between edges → all outputs 0 immediately, `status_out`=0000; after release, ADD (`wb_en_in`=1, dest 3, result 0x5) → `dest_out`=3, `alu_result_out`=0x00000005 next edge.
- Flag set: `valid_in`=1, `s_in`=1, `alu_result_in`=0, `status_in`=0110 → next edge `status_out`=0110; next instruction with `s_in`=0, `status_in`=1000 → `status_out` stays 0110.
- Freeze: hold `freeze`=1 for 3 cycles while inputs change (result 0xDEADBEEF, `s_in`=1, status 1001) → outputs and `status_out` unchanged; on release, next edge loads 0xDEADBEEF and status 1001.
- Flush while frozen: `freeze`=1, pulse `flush` twice, release; incoming ADD `wb_en_in`=1, `s_in`=1 → `valid_out`=0, `wb_en_out`=0, status unchanged; following SUB passes normally.
- Forwarding: LDR (`mem_r_en_in`=1, `wb_en_in`=1) → `fwd_valid`=0; then ADD `wb_en_in`=1 → `fwd_valid`=1; then STR (`mem_w_en_in`=1, `wb_en_in`=0) → `fwd_valid`=0.
- Macro off: repeat flag-set scenario without `EXE_STATUS_REG_EN` → `status_out`=0000 throughout, datapath identical.

Source files
------------

// File: rtl/exe_mem_stage_reg_if.sv
// exe_mem_stage_reg_if: EXE->MEM stage bus (control, stall/flush, datapath, NZCV)
interface exe_mem_stage_reg_if;
    logic        freeze;
    logic        flush;
    logic        valid_in;
    logic        wb_en_in;
    logic        mem_r_en_in;
    logic        mem_w_en_in;
    logic        s_in;
    logic [3:0]  dest_in;
    logic [31:0] alu_result_in;
    logic [31:0] val_rm_in;
    logic [3:0]  status_in;
    logic        valid_out;
    logic        wb_en_out;
    logic        mem_r_en_out;
    logic        mem_w_en_out;
    logic [3:0]  dest_out;
    logic [31:0] alu_result_out;
    logic [31:0] val_rm_out;
    logic [3:0]  status_out;
    logic        fwd_valid;

    modport master (
        output freeze, flush, valid_in, wb_en_in, mem_r_en_in, mem_w_en_in, s_in,
               dest_in, alu_result_in, val_rm_in, status_in,
        input  valid_out, wb_en_out, mem_r_en_out, mem_w_en_out, dest_out,
               alu_result_out, val_rm_out, status_out, fwd_valid
    );

    modport slave (
        input  freeze, flush, valid_in, wb_en_in, mem_r_en_in, mem_w_en_in, s_in,
               dest_in, alu_result_in, val_rm_in, status_in,
        output valid_out, wb_en_out, mem_r_en_out, mem_w_en_out, dest_out,
               alu_result_out, val_rm_out, status_out, fwd_valid
    );
endinterface

// File: rtl/exe_mem_stage_reg.sv
// exe_mem_stage_reg: EXE->MEM pipeline register with freeze, flush retention and NZCV (EXE_STATUS_REG_EN)
module exe_mem_stage_reg (
    input logic clk,
    input logic rst_n,
    exe_mem_stage_reg_if.slave bus
);
    logic        flush_pending;
    logic        squash;
    logic        valid_q;
    logic        wb_q;
    logic        mr_q;
    logic        mw_q;
    logic [3:0]  dest_q;
    logic [31:0] res_q;
    logic [31:0] rm_q;

    assign squash = bus.flush | flush_pending;

    // Pipeline register: hold on freeze (remembering one flush), squash control on flush
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flush_pending <= 1'b0;
            valid_q       <= 1'b0;
            wb_q          <= 1'b0;
            mr_q          <= 1'b0;
            mw_q          <= 1'b0;
            dest_q        <= 4'd0;
            res_q         <= 32'd0;
            rm_q          <= 32'd0;
        end else if (bus.freeze) begin
            if (bus.flush) flush_pending <= 1'b1;
        end else if (squash) begin
            flush_pending <= 1'b0;
            valid_q       <= 1'b0;
            wb_q          <= 1'b0;
            mr_q          <= 1'b0;
            mw_q          <= 1'b0;
        end else begin
            valid_q <= bus.valid_in;
            wb_q    <= bus.wb_en_in;
            mr_q    <= bus.mem_r_en_in;
            mw_q    <= bus.mem_w_en_in;
            dest_q  <= bus.dest_in;
            res_q   <= bus.alu_result_in;
            rm_q    <= bus.val_rm_in;
        end
    end

`ifdef EXE_STATUS_REG_EN
    logic [3:0] status_q;

    // NZCV updates only for a real, unsquashed, flag-setting instruction on an advance edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) status_q <= 4'd0;
        else if (!bus.freeze && !squash && bus.valid_in && bus.s_in) status_q <= bus.status_in;
    end

    assign bus.status_out = status_q;
`else
    logic unused_status;
    assign unused_status  = ^{bus.s_in, bus.status_in};
    assign bus.status_out = 4'd0;
`endif

    assign bus.valid_out      = valid_q;
    assign bus.wb_en_out      = wb_q;
    assign bus.mem_r_en_out   = mr_q;
    assign bus.mem_w_en_out   = mw_q;
    assign bus.dest_out       = dest_q;
    assign bus.alu_result_out = res_q;
    assign bus.val_rm_out     = rm_q;
    assign bus.fwd_valid      = valid_q & wb_q & ~mr_q;
endmodule

// File: tb/tb_exe_mem_stage_reg.sv
// tb_exe_mem_stage_reg: directed self-checking bench for exe_mem_stage_reg
module tb_exe_mem_stage_reg;
`ifdef EXE_STATUS_REG_EN
    localparam bit SEN = 1'b1;
`else
    localparam bit SEN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    int checks = 0;
    int failures = 0;

    exe_mem_stage_reg_if bus ();
    exe_mem_stage_reg dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    function automatic logic [31:0] es(input logic [3:0] v);
        return SEN ? {28'd0, v} : 32'd0;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic wb, input logic mr, input logic mw, input logic s,
                         input logic [3:0] d, input logic [31:0] r, input logic [31:0] rm, input logic [3:0] st);
        bus.valid_in      = v;
        bus.wb_en_in      = wb;
        bus.mem_r_en_in   = mr;
        bus.mem_w_en_in   = mw;
        bus.s_in          = s;
        bus.dest_in       = d;
        bus.alu_result_in = r;
        bus.val_rm_in     = rm;
        bus.status_in     = st;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_valid"}, {31'd0, bus.valid_out}, 32'd0);
        check({tag, "_ctrl"}, {29'd0, bus.wb_en_out, bus.mem_r_en_out, bus.mem_w_en_out}, 32'd0);
        check({tag, "_dest"}, {28'd0, bus.dest_out}, 32'd0);
        check({tag, "_res"}, bus.alu_result_out, 32'd0);
        check({tag, "_rm"}, bus.val_rm_out, 32'd0);
        check({tag, "_status"}, {28'd0, bus.status_out}, 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        bus.freeze = 1'b0;
        bus.flush  = 1'b0;
        drive(1, 1, 1, 1, 1, 4'hF, 32'h12345678, 32'hCAFEBABE, 4'b1111);
        #2 rst_n = 1'b1;
        // Load nonzero everything, then async reset between edges
        tick;
        check("pre_rst_dest", {28'd0, bus.dest_out}, 32'hF);
        check("pre_rst_status", {28'd0, bus.status_out}, es(4'b1111));
        #2 rst_n = 1'b0;
        #1;
        check_zero("rst");
        drive(1, 1, 0, 0, 0, 4'd3, 32'h5, 32'h0, 4'b0000);
        #1 rst_n = 1'b1;
        tick;
        check("add_dest", {28'd0, bus.dest_out}, 32'd3);
        check("add_res", bus.alu_result_out, 32'h5);
        check("add_valid", {31'd0, bus.valid_out}, 32'd1);
        check("add_fwd", {31'd0, bus.fwd_valid}, 32'd1);
        // Flag set, then non-S instruction leaves flags alone
        drive(1, 1, 0, 0, 1, 4'd1, 32'h0, 32'h0, 4'b0110);
        tick;
        check("flag_set", {28'd0, bus.status_out}, es(4'b0110));
        check("flag_res", bus.alu_result_out, 32'h0);
        drive(1, 1, 0, 0, 0, 4'd2, 32'h11, 32'h0, 4'b1000);
        tick;
        check("flag_hold", {28'd0, bus.status_out}, es(4'b0110));
        check("flag_hold_res", bus.alu_result_out, 32'h11);
        // Freeze for three edges while inputs change
        bus.freeze = 1'b1;
        drive(1, 1, 0, 0, 1, 4'd5, 32'hDEADBEEF, 32'h77, 4'b1001);
        tick;
        check("frz1_res", bus.alu_result_out, 32'h11);
        tick;
        tick;
        check("frz3_res", bus.alu_result_out, 32'h11);
        check("frz3_dest", {28'd0, bus.dest_out}, 32'd2);
        check("frz3_status", {28'd0, bus.status_out}, es(4'b0110));
        bus.freeze = 1'b0;
        tick;
        check("unfrz_res", bus.alu_result_out, 32'hDEADBEEF);
        check("unfrz_rm", bus.val_rm_out, 32'h77);
        check("unfrz_dest", {28'd0, bus.dest_out}, 32'd5);
        check("unfrz_status", {28'd0, bus.status_out}, es(4'b1001));
        // Two flushes while frozen squash exactly one instruction
        bus.freeze = 1'b1;
        bus.flush  = 1'b1;
        drive(1, 1, 0, 0, 1, 4'd7, 32'hAAAA, 32'h1, 4'b0011);
        tick;
        bus.flush = 1'b0;
        tick;
        bus.flush = 1'b1;
        tick;
        check("ffz_hold_valid", {31'd0, bus.valid_out}, 32'd1);
        bus.flush  = 1'b0;
        bus.freeze = 1'b0;
        tick;
        check("ffz_valid", {31'd0, bus.valid_out}, 32'd0);
        check("ffz_wb", {31'd0, bus.wb_en_out}, 32'd0);
        check("ffz_dest", {28'd0, bus.dest_out}, 32'd5);
        check("ffz_res", bus.alu_result_out, 32'hDEADBEEF);
        check("ffz_status", {28'd0, bus.status_out}, es(4'b1001));
        check("ffz_fwd", {31'd0, bus.fwd_valid}, 32'd0);
        drive(1, 1, 0, 0, 1, 4'd8, 32'h20, 32'h0, 4'b0100);
        tick;
        check("sub_valid", {31'd0, bus.valid_out}, 32'd1);
        check("sub_res", bus.alu_result_out, 32'h20);
        check("sub_dest", {28'd0, bus.dest_out}, 32'd8);
        check("sub_status", {28'd0, bus.status_out}, es(4'b0100));
        // Direct flush on an advance edge
        bus.flush = 1'b1;
        drive(1, 1, 0, 0, 1, 4'd9, 32'h99, 32'h0, 4'b1111);
        tick;
        check("dfl_valid", {31'd0, bus.valid_out}, 32'd0);
        check("dfl_res", bus.alu_result_out, 32'h20);
        check("dfl_status", {28'd0, bus.status_out}, es(4'b0100));
        bus.flush = 1'b0;
        // Forwarding: LDR, ADD, STR
        drive(1, 1, 1, 0, 0, 4'd9, 32'h100, 32'h0, 4'b0000);
        tick;
        check("ldr_mr", {31'd0, bus.mem_r_en_out}, 32'd1);
        check("ldr_fwd", {31'd0, bus.fwd_valid}, 32'd0);
        drive(1, 1, 0, 0, 0, 4'd10, 32'h5, 32'h0, 4'b0000);
        tick;
        check("fadd_fwd", {31'd0, bus.fwd_valid}, 32'd1);
        drive(1, 0, 0, 1, 0, 4'd0, 32'h104, 32'hBEEF, 4'b0000);
        tick;
        check("str_fwd", {31'd0, bus.fwd_valid}, 32'd0);
        check("str_mw", {31'd0, bus.mem_w_en_out}, 32'd1);
        check("str_rm", bus.val_rm_out, 32'hBEEF);
        // Bubble with S set must not touch flags
        drive(0, 0, 0, 0, 1, 4'd4, 32'h44, 32'h0, 4'b1010);
        tick;
        check("bub_valid", {31'd0, bus.valid_out}, 32'd0);
        check("bub_res", bus.alu_result_out, 32'h44);
        check("bub_status", {28'd0, bus.status_out}, es(4'b0100));
        // Reset while frozen with a pending flush
        bus.freeze = 1'b1;
        bus.flush  = 1'b1;
        tick;
        #2 rst_n = 1'b0;
        #1;
        check_zero("rst2");
        bus.freeze = 1'b0;
        bus.flush  = 1'b0;
        drive(1, 1, 0, 0, 1, 4'd6, 32'h66, 32'h3, 4'b0001);
        #1 rst_n = 1'b1;
        tick;
        check("post_rst2_valid", {31'd0, bus.valid_out}, 32'd1);
        check("post_rst2_res", bus.alu_result_out, 32'h66);
        check("post_rst2_status", {28'd0, bus.status_out}, es(4'b0001));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
